// File: rtl/apb_scan_ctrl.sv
// APB register slave driving a scan chain: capture, LEN-bit shift with divided scan_clk, update.
// APB accesses complete in setup+access (pready tied high); scan outputs are registered, 1 clk after state change.
// No backpressure: busy/done are polled through STATUS; config writes and START are dropped while busy.
// Optional feature macro: SCAN_LOOPBACK_EN (adds CTRL bit3 LOOP, sample taken from scan_out instead of scan_in).
module apb_scan_ctrl #(
    parameter int PADDR_WL = 8,
    parameter int PDATA_WL = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [PADDR_WL-1:0] paddr,
    input  logic [PDATA_WL-1:0] pwdata,
    output logic [PDATA_WL-1:0] prdata,
    output logic                pready,
    output logic                scan_clk,
    output logic                scan_en,
    output logic                scan_out,
    input  logic                scan_in,
    output logic                scan_capture,
    output logic                scan_update
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] shift_buf;
    logic [31:0] buf_shift;
    logic [5:0]  len_q;
    logic [5:0]  bit_cnt;
    logic [7:0]  div_q;
    logic [7:0]  div_cnt;
    logic        busy;
    logic        done;
    logic        upd_en;
    logic        sample_bit;
    logic [4:0]  len_idx;
    logic [2:0]  addr;
    logic        wr_en;
    logic        cfg_wr;
    logic        start_req;
    logic [7:0]  rd_val;
    logic        unused_paddr_hi;

    assign pready          = 1'b1;
    assign addr            = paddr[2:0];
    assign unused_paddr_hi = &{1'b0, paddr[PADDR_WL-1:3]};
    assign wr_en           = psel & penable & pwrite;
    assign cfg_wr          = wr_en & ~busy;
    assign start_req       = cfg_wr && (addr == 3'd0) && pwdata[0];
    // LEN is 1..32 whenever a shift runs, so LEN-1 always fits in 5 bits
    assign len_idx         = 5'(len_q - 6'd1);

`ifdef SCAN_LOOPBACK_EN
    logic loop_en;
    // Loopback feeds the bit currently driven out back into the top of the window
    assign sample_bit = loop_en ? scan_out : scan_in;
`else
    assign sample_bit = scan_in;
`endif

    // Next buffer value on a shift: move right, insert the sampled bit at LEN-1
    always_comb begin
        buf_shift          = shift_buf >> 1;
        buf_shift[len_idx] = sample_bit;
    end

    // Read mux: only live during a read select, zero otherwise; no side effects
    always_comb begin
        rd_val = 8'h00;
        if (psel && !pwrite) begin
            case (addr)
                3'd1:    rd_val = {6'b0, done, busy};
                3'd2:    rd_val = {2'b0, len_q};
                3'd3:    rd_val = div_q;
                3'd4,
                3'd5,
                3'd6,
                3'd7:    rd_val = shift_buf[{addr[1:0], 3'b000} +: 8];
                default: rd_val = 8'h00;
            endcase
        end
    end

    assign prdata = rd_val;

    // LEN and DIV configuration, frozen while a shift is in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= 6'd0;
            div_q <= 8'd0;
        end else if (cfg_wr) begin
            if (addr == 3'd2) len_q <= (pwdata[7:0] > 8'd32) ? 6'd32 : pwdata[5:0];
            if (addr == 3'd3) div_q <= pwdata[7:0];
        end
    end

    // Sequencer: owns the shift buffer, status flags and every scan output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            shift_buf    <= 32'd0;
            bit_cnt      <= 6'd0;
            div_cnt      <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            upd_en       <= 1'b0;
`ifdef SCAN_LOOPBACK_EN
            loop_en      <= 1'b0;
`endif
            scan_clk     <= 1'b0;
            scan_en      <= 1'b0;
            scan_out     <= 1'b0;
            scan_capture <= 1'b0;
            scan_update  <= 1'b0;
        end else begin
            scan_capture <= 1'b0;
            scan_update  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_wr && addr[2]) begin
                        shift_buf[{addr[1:0], 3'b000} +: 8] <= pwdata[7:0];
                    end
                    if (start_req) begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        upd_en  <= pwdata[2];
`ifdef SCAN_LOOPBACK_EN
                        loop_en <= pwdata[3];
`endif
                        bit_cnt <= len_q;
                        div_cnt <= 8'd0;
                        if (len_q != 6'd0) begin
                            if (pwdata[1]) begin
                                state        <= S_CAPTURE;
                                scan_capture <= 1'b1;
                            end else begin
                                state    <= S_SHIFT_LO;
                                scan_en  <= 1'b1;
                                scan_clk <= 1'b0;
                                scan_out <= shift_buf[0];
                            end
                        end else if (pwdata[2]) begin
                            state       <= S_UPDATE;
                            scan_update <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_CAPTURE: begin
                    state    <= S_SHIFT_LO;
                    scan_en  <= 1'b1;
                    scan_clk <= 1'b0;
                    scan_out <= shift_buf[0];
                    div_cnt  <= 8'd0;
                end
                S_SHIFT_LO: begin
                    if (div_cnt == div_q) begin
                        state    <= S_SHIFT_HI;
                        scan_clk <= 1'b1;
                        div_cnt  <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (div_cnt == div_q) begin
                        shift_buf <= buf_shift;
                        bit_cnt   <= bit_cnt - 6'd1;
                        div_cnt   <= 8'd0;
                        scan_clk  <= 1'b0;
                        if (bit_cnt == 6'd1) begin
                            scan_en  <= 1'b0;
                            scan_out <= 1'b0;
                            if (upd_en) begin
                                state       <= S_UPDATE;
                                scan_update <= 1'b1;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            state    <= S_SHIFT_LO;
                            scan_out <= buf_shift[0];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_UPDATE: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_scan_ctrl.sv
// Directed bench for apb_scan_ctrl with a 16-bit scan chain model behind a lockup latch.
// Each task drives one scenario and checks against hand-computed values.
// All APB activity and sampling happen on the falling clock edge.
module tb_apb_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       scan_clk, scan_en, scan_out, scan_in, scan_capture, scan_update;

    int n_pass  = 0;
    int n_total = 0;

    apb_scan_ctrl #(.PADDR_WL(8), .PDATA_WL(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .scan_clk     (scan_clk),
        .scan_en      (scan_en),
        .scan_out     (scan_out),
        .scan_in      (scan_in),
        .scan_capture (scan_capture),
        .scan_update  (scan_update)
    );

    always #5 clk = ~clk;

    // Chain shifts on scan_clk rise; SO is held through the high phase
    logic [15:0] chain   = 16'h1234;
    logic        so_hold = 1'b0;
    logic [31:0] out_sr  = 32'd0;
    int          rise_cnt = 0;
    assign scan_in = so_hold;

    always @(posedge scan_clk) begin
        so_hold  <= chain[0];
        chain    <= {scan_out, chain[15:1]};
        out_sr   <= {scan_out, out_sr[31:1]};
        rise_cnt <= rise_cnt + 1;
    end

    int   hi_cyc = 0, cap_cnt = 0, upd_cnt = 0, cap_rise = -1, upd_rise = -1;
    logic upd_clk = 1'b0;

    always @(negedge clk) begin
        if (scan_clk) hi_cyc <= hi_cyc + 1;
        if (scan_capture) begin
            cap_cnt  <= cap_cnt + 1;
            cap_rise <= rise_cnt;
        end
        if (scan_update) begin
            upd_cnt  <= upd_cnt + 1;
            upd_rise <= rise_cnt;
            upd_clk  <= scan_clk;
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Poll STATUS until BUSY clears; a timeout leaves BUSY set in st
    task automatic wait_idle(output logic [7:0] st);
        st = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            apb_read(8'd1, st);
            if (!st[0]) break;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({scan_clk, scan_en, scan_out, scan_capture, scan_update} !== 5'b0) begin
            $display("FAIL reset_scan_outs got=%b exp=00000",
                     {scan_clk, scan_en, scan_out, scan_capture, scan_update});
        end else n_pass++;
        reset = 1'b0;
        n_total++;
        if (pready !== 1'b1) $display("FAIL reset_pready got=%b exp=1", pready);
        else n_pass++;
        for (int r = 0; r < 8; r++) begin
            apb_read(8'(r), d);
            n_total++;
            if (d !== 8'h00) $display("FAIL reset_reg%0d got=%h exp=00", r, d);
            else n_pass++;
        end
    endtask

    task automatic test_shift16();
        logic [7:0] d;
        int r0, h0, c0;
        apb_write(8'd4, 8'hA5);
        apb_write(8'd5, 8'h3C);
        apb_write(8'd6, 8'h00);
        apb_write(8'd7, 8'h00);
        apb_write(8'd2, 8'd16);
        apb_write(8'd3, 8'd1);
        r0 = rise_cnt; h0 = hi_cyc; c0 = cap_cnt;
        apb_write(8'd0, 8'h01);
        apb_read(8'd1, d);
        n_total++;
        if (d !== 8'h01) $display("FAIL shift16_status_busy got=%h exp=01", d);
        else n_pass++;
        wait_idle(d);
        n_total++;
        if (d !== 8'h02) $display("FAIL shift16_status_done got=%h exp=02", d);
        else n_pass++;
        n_total++;
        if (rise_cnt - r0 !== 16) $display("FAIL shift16_pulses got=%0d exp=16", rise_cnt - r0);
        else n_pass++;
        n_total++;
        if (hi_cyc - h0 !== 32) $display("FAIL shift16_hi_cycles got=%0d exp=32", hi_cyc - h0);
        else n_pass++;
        n_total++;
        if (out_sr[31:16] !== 16'h3CA5) $display("FAIL shift16_scan_out got=%h exp=3ca5", out_sr[31:16]);
        else n_pass++;
        n_total++;
        if (chain !== 16'h3CA5) $display("FAIL shift16_chain got=%h exp=3ca5", chain);
        else n_pass++;
        apb_read(8'd4, d);
        n_total++;
        if (d !== 8'h34) $display("FAIL shift16_buf0 got=%h exp=34", d);
        else n_pass++;
        apb_read(8'd5, d);
        n_total++;
        if (d !== 8'h12) $display("FAIL shift16_buf1 got=%h exp=12", d);
        else n_pass++;
        n_total++;
        if (cap_cnt !== c0) $display("FAIL shift16_no_capture got=%0d exp=%0d", cap_cnt, c0);
        else n_pass++;
    endtask

    task automatic test_cap_upd();
        logic [7:0] d;
        int r0, c0, u0;
        apb_write(8'd2, 8'd8);
        apb_write(8'd3, 8'd0);
        r0 = rise_cnt; c0 = cap_cnt; u0 = upd_cnt;
        apb_write(8'd0, 8'h07);
        wait_idle(d);
        n_total++;
        if (d !== 8'h02) $display("FAIL capupd_status got=%h exp=02", d);
        else n_pass++;
        n_total++;
        if (rise_cnt - r0 !== 8) $display("FAIL capupd_pulses got=%0d exp=8", rise_cnt - r0);
        else n_pass++;
        n_total++;
        if (cap_cnt - c0 !== 1) $display("FAIL capupd_cap_count got=%0d exp=1", cap_cnt - c0);
        else n_pass++;
        n_total++;
        if (cap_rise !== r0) $display("FAIL capupd_cap_before_rise got=%0d exp=%0d", cap_rise, r0);
        else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== 1) $display("FAIL capupd_upd_count got=%0d exp=1", upd_cnt - u0);
        else n_pass++;
        n_total++;
        if (upd_rise !== r0 + 8 || upd_clk !== 1'b0) begin
            $display("FAIL capupd_upd_after_fall got=rise%0d/clk%b exp=rise%0d/clk0", upd_rise, upd_clk, r0 + 8);
        end else n_pass++;
    endtask

    task automatic test_len0();
        logic [7:0] d;
        int r0, u0;
        apb_write(8'd2, 8'd0);
        r0 = rise_cnt; u0 = upd_cnt;
        apb_write(8'd0, 8'h05);
        apb_read(8'd1, d);
        n_total++;
        if (d !== 8'h02) $display("FAIL len0_status got=%h exp=02", d);
        else n_pass++;
        n_total++;
        if (rise_cnt - r0 !== 0) $display("FAIL len0_no_pulses got=%0d exp=0", rise_cnt - r0);
        else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== 1) $display("FAIL len0_update got=%0d exp=1", upd_cnt - u0);
        else n_pass++;
    endtask

    // Chain holds 0x343C here, so an 8-bit shift loads BUF0 with 0x3C
    task automatic test_busy_ignore();
        logic [7:0] d;
        int r0;
        apb_write(8'd4, 8'h5A);
        apb_write(8'd2, 8'd8);
        apb_write(8'd3, 8'd3);
        r0 = rise_cnt;
        apb_write(8'd0, 8'h01);
        apb_write(8'd4, 8'hFF);
        apb_write(8'd2, 8'd3);
        apb_write(8'd0, 8'h01);
        wait_idle(d);
        n_total++;
        if (rise_cnt - r0 !== 8) $display("FAIL busy_pulses got=%0d exp=8", rise_cnt - r0);
        else n_pass++;
        apb_read(8'd2, d);
        n_total++;
        if (d !== 8'd8) $display("FAIL busy_len got=%h exp=08", d);
        else n_pass++;
        apb_read(8'd4, d);
        n_total++;
        if (d !== 8'h3C) $display("FAIL busy_buf0 got=%h exp=3c", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       found;
        found = 1'b0;
        apb_write(8'd2, 8'd16);
        apb_write(8'd3, 8'd2);
        apb_write(8'd0, 8'h01);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scan_clk === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (found !== 1'b1) $display("FAIL midrst_reached_hi got=%b exp=1", found);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({scan_clk, scan_en} !== 2'b00) $display("FAIL midrst_async_drop got=%b exp=00", {scan_clk, scan_en});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        apb_read(8'd1, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL midrst_status got=%h exp=00", d);
        else n_pass++;
        apb_read(8'd4, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL midrst_buf0 got=%h exp=00", d);
        else n_pass++;
    endtask

    task automatic test_len_sat();
        logic [7:0] d;
        apb_write(8'd2, 8'd40);
        apb_read(8'd2, d);
        n_total++;
        if (d !== 8'd32) $display("FAIL lensat_40 got=%0d exp=32", d);
        else n_pass++;
        apb_write(8'd2, 8'd32);
        apb_read(8'd2, d);
        n_total++;
        if (d !== 8'd32) $display("FAIL lensat_32 got=%0d exp=32", d);
        else n_pass++;
        apb_write(8'd2, 8'd33);
        apb_read(8'd2, d);
        n_total++;
        if (d !== 8'd32) $display("FAIL lensat_33 got=%0d exp=32", d);
        else n_pass++;
        apb_write(8'd3, 8'h77);
        apb_read(8'd3, d);
        n_total++;
        if (d !== 8'h77) $display("FAIL div_readback got=%h exp=77", d);
        else n_pass++;
        apb_read(8'd0, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL ctrl_reads_zero got=%h exp=00", d);
        else n_pass++;
    endtask

`ifdef SCAN_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] d;
        apb_write(8'd4, 8'h81);
        apb_write(8'd2, 8'd8);
        apb_write(8'd3, 8'd0);
        apb_write(8'd0, 8'h09);
        wait_idle(d);
        n_total++;
        if (d !== 8'h02) $display("FAIL loop_status got=%h exp=02", d);
        else n_pass++;
        apb_read(8'd4, d);
        n_total++;
        if (d !== 8'h81) $display("FAIL loop_buf0 got=%h exp=81", d);
        else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'd0; pwdata = 8'd0;
        test_reset();
        test_shift16();
        test_cap_upd();
        test_len0();
        test_busy_ignore();
        test_reset_mid();
        test_len_sat();
`ifdef SCAN_LOOPBACK_EN
        test_loopback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
